// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the seq_mul radix-2 shift-add multiplier.
package seq_mul_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W     = $clog2(WIDTH_DEF + 1);

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    // 0x80000000 negates to itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH_DEF-1:0] magnitude(input logic [WIDTH_DEF-1:0] v,
                                                       input logic                 is_signed);
        return (is_signed && v[WIDTH_DEF-1]) ? (~v + WIDTH_DEF'(1)) : v;
    endfunction

endpackage

// File: rtl/adder_nb.sv
// Plain N-bit ripple-carry adder used for the multiplier's partial-product accumulate.
module adder_nb #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic carry;

    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/seq_mul.sv
// Iterative RV32M multiplier: one shift-add step per cycle, WIDTH+1 cycle latency.
// Optional macro SEQ_MUL_ZERO_BYPASS_EN skips the iterations when either operand is zero.
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_e             state;
    state_e             state_next;
    logic [CNT_W-1:0]   counter;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_next;
    logic [2*WIDTH-1:0] final_product;
    logic [WIDTH-1:0]   mag_a;
    logic               neg;
    op_e                op_q;
    op_e                op_in;
    logic               accept;
    logic               last_iter;
    logic               a_signed;
    logic               b_signed;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [WIDTH:0]     upper_next;

    assign op_in    = op_e'(op);
    assign a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU);
    assign b_signed = (op_in == OP_MULH);

`ifdef SEQ_MUL_ZERO_BYPASS_EN
    logic zero_op;
    assign zero_op = (a == '0) || (b == '0);
`endif

    adder_nb #(.WIDTH(WIDTH)) u_adder (
        .a    (product[2*WIDTH-1:WIDTH]),
        .b    (mag_a),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // The carry out becomes the new top bit after the one-place right shift.
    assign upper_next    = product[0] ? {add_cout, add_sum} : {1'b0, product[2*WIDTH-1:WIDTH]};
    assign product_next  = {upper_next, product[WIDTH-1:1]};
    assign final_product = neg ? (~product_next + (2*WIDTH)'(1)) : product_next;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_iter  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept = 1'b1;
`ifdef SEQ_MUL_ZERO_BYPASS_EN
                    state_next = zero_op ? DONE : CALC;
`else
                    state_next = CALC;
`endif
                end else if (state == DONE) begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                if (counter == CNT_W'(WIDTH - 1)) begin
                    last_iter  = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
            product <= '0;
            mag_a   <= '0;
            neg     <= 1'b0;
            op_q    <= OP_MUL;
            result  <= '0;
        end else if (accept) begin
            mag_a   <= magnitude(a, a_signed);
            product <= {{WIDTH{1'b0}}, magnitude(b, b_signed)};
            neg     <= (a_signed & a[WIDTH-1]) ^ (b_signed & b[WIDTH-1]);
            op_q    <= op_in;
            counter <= '0;
`ifdef SEQ_MUL_ZERO_BYPASS_EN
            if (zero_op) result <= '0;
`endif
        end else if (state == CALC) begin
            product <= product_next;
            counter <= counter + CNT_W'(1);
            if (last_iter)
                result <= (op_q == OP_MUL) ? final_product[WIDTH-1:0]
                                           : final_product[2*WIDTH-1:WIDTH];
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul: directed RV32M corner cases plus randomized operations
// compared against a wide signed-arithmetic reference model.
module tb_seq_mul;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    seq_mul dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: sign/zero-extend both operands to 66 bits and multiply directly.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [65:0] ex;
        logic signed [65:0] ey;
        logic signed [65:0] p;
        ex = (o == 2'b01 || o == 2'b10) ? $signed({{34{x[31]}}, x}) : $signed({34'b0, x});
        ey = (o == 2'b01) ? $signed({{34{y[31]}}, y}) : $signed({34'b0, y});
        p  = ex * ey;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int latency(input logic [31:0] x, input logic [31:0] y);
`ifdef SEQ_MUL_ZERO_BYPASS_EN
        if (x == 32'd0 || y == 32'd0) return 1;
`endif
        return 33;
    endfunction

    // Issues one operation in the current cycle and returns in the cycle where done should be high.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit inject);
        int          lat;
        bit          timing_ok;
        int          bad_cycle;
        logic [31:0] exp;
        lat       = latency(x, y);
        exp       = model(o, x, y);
        timing_ok = 1'b1;
        bad_cycle = 0;
        op = o; a = x; b = y; start = 1'b1;
        step();
        start = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
        for (int k = 1; k <= lat; k++) begin
            if (k < lat) begin
                if (busy !== 1'b1 || done !== 1'b0) begin
                    if (timing_ok) bad_cycle = k;
                    timing_ok = 1'b0;
                end
                start = inject && (k == 5 || k == 20);
                step();
            end else begin
                if (busy !== 1'b0 || done !== 1'b1) begin
                    if (timing_ok) bad_cycle = k;
                    timing_ok = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (!timing_ok) begin
            errors++;
            $display("[TB] FAIL %s timing: busy/done wrong at cycle T+%0d (done due at T+%0d)", name, bad_cycle, lat);
        end
        checks++;
        if (result !== exp) begin
            errors++;
            $display("[TB] FAIL %s result: got %h expected %h", name, result, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        step(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset done: got %b expected 0", done); end
        checks++; if (result !== 32'd0) begin errors++; $display("[TB] FAIL reset result: got %h expected 0", result); end
        start = 1'b1; a = 32'd7; b = 32'd6;
        step();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL reset_vs_start: busy=%b done=%b expected 0/0", busy, done); end
        start = 1'b0; rst = 1'b0;
        step();
    endtask

    task automatic test_directed();
        run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 1'b0);
        run_op("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("mul_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mulhsu_neg1x2", 2'b10, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op("mulh_neg1xneg1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        step(); step();
    endtask

    task automatic test_back_to_back();
        run_op("ignored_starts", 2'b01, 32'h1234_5678, 32'h8765_4321, 1'b1);
        run_op("b2b_mul_3x5", 2'b00, 32'd3, 32'd5, 1'b0);
        step();
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        op = 2'b11; a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 10; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid: busy=%b done=%b result=%h expected 0/0/0", busy, done, result);
        end
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done !== 1'b0) saw_done = 1'b1;
            step();
        end
        checks++;
        if (saw_done) begin errors++; $display("[TB] FAIL reset_mid_no_done: got done=1 expected none"); end
        run_op("after_reset_9x9", 2'b00, 32'd9, 32'd9, 1'b0);
        step();
    endtask

    task automatic test_zero();
        run_op("zero_a_mul", 2'b00, 32'd0, 32'h0000_1234, 1'b0);
        run_op("zero_b_mulh", 2'b01, 32'hFFFF_FFF0, 32'd0, 1'b0);
        step();
    endtask

    task automatic test_random();
        logic [31:0] corners [5];
        logic [31:0] x;
        logic [31:0] y;
        corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001; corners[2] = 32'h7FFF_FFFF;
        corners[3] = 32'h8000_0000; corners[4] = 32'hFFFF_FFFF;
        for (int i = 0; i < 24; i++) begin
            x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            run_op("random", 2'($urandom), x, y, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) step();
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_zero();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_mul.md
# seq_mul

Iterative radix-2 shift-add multiplier for the RV32M multiply group, sitting beside the execute-stage ALU. It accepts two operands and an op code on a start pulse, accumulates partial products over WIDTH cycles through the team's ripple adder, and returns the selected 32-bit half of the 64-bit product with a one-cycle done pulse. The hazard unit stalls on busy.

## Interface
- WIDTH, 32, operand/result width (only 32 is supported)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when busy==0
- op  in  2  00 MUL (low, any sign), 01 MULH (s×s high), 10 MULHSU (a signed × b unsigned, high), 11 MULHU (u×u high); equals funct3[1:0]
- a  in  WIDTH  multiplicand (rs1)
- b  in  WIDTH  multiplier (rs2)
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, result valid
- result  out  WIDTH  selected product half; held until the next accepted start

## Operation
- States: IDLE, CALC, DONE. Reset enters IDLE with busy=0, done=0, result=0, counter=0, product=0.
- Accept in IDLE or DONE when start=1:
  - latch the magnitudes |a| and |b| per signedness: a is signed for op 01/10, b is signed for op 01 only
  - neg = sign(a) XOR sign(b), counting only operands treated as signed
  - latch op
  - product[2W-1:0] = {W'0, |b|}
  - counter=0
  - go to CALC
- CALC, each cycle:
  - if product[0]=1, the upper half = product[2W-1:W] + |a|, producing a W+1-bit sum (carry out as bit W); otherwise the upper half is unchanged
  - product = {sum_with_carry, product[W-1:1]}, a logical right shift of 2W+1 bits down to 2W
  - counter++
  - after the WIDTH-th iteration, go to DONE
- Leaving CALC: final = neg ? (~product + 1) mod 2^(2W) : product. result = op==00 ? final[W-1:0] : final[2W-1:W].
- DONE: done=1 for exactly one cycle, then IDLE unless a new start is accepted.
- start while busy=1 is ignored: no queuing and no state change.
- Operand changes after acceptance have no effect.
- The most-negative operand, 0x80000000, is valid: its magnitude fits in the W-bit unsigned operand.

## Timing
- Start sampled at edge E0 (cycle T):
  - busy=1 in cycles T+1 … T+WIDTH
  - result is loaded at the edge ending T+WIDTH
  - done=1 and busy=0 in T+WIDTH+1
  - total latency is WIDTH+1 cycles, 33 for the default
- Back-to-back: start in the DONE cycle is accepted, so throughput is one result per 33 cycles.
- done and busy are never high together.
- Reset mid-CALC: next cycle busy=0, done=0, result=0. The operation is dropped and no done is produced.
- rst and start in the same cycle: reset wins.

## Configuration
- SEQ_MUL_ZERO_BYPASS_EN:
  - Defined: if a==0 or b==0 when a start is accepted, CALC is skipped and the block goes directly to DONE with result=0, so done arrives in T+1.
  - Undefined: zero operands take the full WIDTH+1 cycles.
  - The result value is identical in both cases.

## Structure
- seq_mul_pkg:
  - op_e enum (OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU)
  - state_e enum (IDLE, CALC, DONE)
  - localparam CNT_W = $clog2(WIDTH+1)
- Sub-module: one instance of the existing adder_nb (WIDTH=32) for the upper-half accumulate.
  - cin tied to 0; cout is then the true carry into bit W.
  - The final two's-complement negation is a separate combinational increment, not a second adder_nb.

## Test plan
- MUL a=7, b=6, start at T -> busy for 32 cycles, done only at T+33, result=0x0000002A.
- MULH a=0x80000000, b=0x80000000 -> result=0x40000000. MUL with the same operands -> 0x00000000.
- MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF. MULH a=0xFFFFFFFF, b=0xFFFFFFFF -> 0x00000000.
- Start pulses in cycles T+5 and T+20 are ignored. A start in the DONE cycle (MUL 3×5) -> the next done is 33 cycles later with result=0x0000000F.
- rst asserted at T+10 of a MULHU -> next cycle busy=0, done=0, result=0, and no done follows. A fresh MUL 9×9 then -> 0x00000051.
- a=0, b=0x1234, MUL:
  - with SEQ_MUL_ZERO_BYPASS_EN -> done at T+1, result=0
  - without it -> done at T+33, result=0
